// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit restoring radix-2 divider for the E stage.
// Serves DIV/DIVU, produces {remainder, quotient} for the HI/LO write path and
// holds the pipeline through div_stallE while a division is in flight.
// Optional build macro: DIV_ZERO_FAST_EN - a zero divisor finishes in one cycle
// instead of running the full 32 iterations.
module div_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        signed_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stall_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] a_lat;      // raw dividend, returned as HI on divide by zero
    logic [31:0] div_mag;    // divisor magnitude
    logic [31:0] rem;        // partial remainder
    logic [31:0] quo;        // dividend magnitude shifting out, quotient shifting in
    logic        sign_q;
    logic        sign_r;
    logic        div_zero;
    logic        ready_q;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] rem_sh;
    logic        fits;
    logic [31:0] diff;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;
    logic [31:0] quo_fin;
    logic [31:0] rem_fin;

    // Two's complement negate when requested; used for magnitudes and sign fix-up.
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        logic signed [31:0] sv;
        sv = $signed(v);
        return neg ? $unsigned(-sv) : v;
    endfunction

    assign a_mag = cond_neg(a_i, signed_i & a_i[31]);
    assign b_mag = cond_neg(b_i, signed_i & b_i[31]);

    // One restoring step: shift, trial-subtract, keep the difference if it fits.
    always_comb begin
        rem_sh  = {rem, quo[31]};
        fits    = (rem_sh >= {1'b0, div_mag});
        // The true difference is below 2^32 whenever it is kept, so 32 bits suffice.
        diff    = rem_sh[31:0] - div_mag;
        rem_nxt = rem_sh[31:0];
        quo_nxt = {quo[30:0], 1'b0};
        if (fits) begin
            rem_nxt = diff;
            quo_nxt = {quo[30:0], 1'b1};
        end
        // A zero divisor returns the raw dividend and all-ones, with no sign fix-up.
        quo_fin = div_zero ? 32'hFFFF_FFFF : cond_neg(quo_nxt, sign_q);
        rem_fin = div_zero ? a_lat : cond_neg(rem_nxt, sign_r);
    end

    // FSM, iteration datapath and registered result/ready.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            result_o <= 64'd0;
            ready_q  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            if (annul_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            a_lat    <= a_i;
                            div_mag  <= b_mag;
                            rem      <= 32'd0;
                            quo      <= a_mag;
                            cnt      <= 5'd0;
                            sign_q   <= signed_i & (a_i[31] ^ b_i[31]);
                            sign_r   <= signed_i & a_i[31];
                            div_zero <= (b_i == 32'd0);
`ifdef DIV_ZERO_FAST_EN
                            if (b_i == 32'd0) begin
                                result_o <= {a_i, 32'hFFFF_FFFF};
                                ready_q  <= 1'b1;
                                state    <= DONE;
                            end else begin
                                state <= BUSY;
                            end
`else
                            state <= BUSY;
`endif
                        end
                    end
                    BUSY: begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            result_o <= {rem_fin, quo_fin};
                            ready_q  <= 1'b1;
                            state    <= DONE;
                        end
                    end
                    DONE: begin
                        // start_i here is still the finishing instruction leaving E.
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // A flush in the completion cycle kills the HI/LO write of that instruction.
    assign ready_o = ready_q & ~annul_i;

    // Hold F/D/E from the accepting cycle through the last iteration.
    assign stall_o = ((state == IDLE) & start_i & ~annul_i) |
                     ((state == BUSY) & ~annul_i);

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit. Expected results are queued when a
// divide is launched and compared whenever the DUT raises ready_o.
module tb_div_unit;

    logic        clk;
    logic        resetn;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        signed_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_o;

    int n_vec;
    int n_bad;
    logic [63:0] sbq[$];

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    div_unit dut (
        .clk      (clk),
        .resetn   (resetn),
        .a_i      (a_i),
        .b_i      (b_i),
        .signed_i (signed_i),
        .start_i  (start_i),
        .annul_i  (annul_i),
        .result_o (result_o),
        .ready_o  (ready_o),
        .stall_o  (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: language-level division; zero divisor returns {a, all-ones}.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Result monitor: every ready pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (resetn === 1'b1 && ready_o === 1'b1) begin
            if (sbq.size() == 0)
                check("spurious_ready", 64'(ready_o), 64'd0);
            else
                check("result", result_o, sbq.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick();
        start_i = 1'b0;
        annul_i = 1'b0;
    endtask

    // Launch one divide and check stall/ready timing; start stays high through DONE.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [63:0] exp, input int lat, input string tag);
        tick();
        a_i      = a;
        b_i      = b;
        signed_i = s;
        start_i  = 1'b1;
        annul_i  = 1'b0;
        sbq.push_back(exp);
        #1;
        check({tag, "_stall_start"}, 64'(stall_o), 64'd1);
        for (int k = 1; k < lat; k++) begin
            tick();
            #1;
            check({tag, "_stall_busy"}, 64'(stall_o), 64'd1);
            if (k == lat - 1) check({tag, "_ready_early"}, 64'(ready_o), 64'd0);
        end
        tick();
        #1;
        check({tag, "_ready"}, 64'(ready_o), 64'd1);
        check({tag, "_stall_done"}, 64'(stall_o), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic [63:0] prev;
        n_vec    = 0;
        n_bad    = 0;
        resetn   = 1'b0;
        start_i  = 1'b0;
        annul_i  = 1'b0;
        a_i      = 32'd0;
        b_i      = 32'd0;
        signed_i = 1'b0;

        tick();
        tick();
        #1;
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_result", result_o, 64'd0);
        check("rst_stall", 64'(stall_o), 64'd0);
        tick();
        resetn = 1'b1;
        idle();

        run_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, "divu_100_7");
        idle();
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "div_m7_2");
        idle();
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD}, 33, "div_7_m2");
        idle();
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, {32'd0, 32'hFFFF_FFFF}, 33, "divu_max_1");
        idle();
        run_div(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, {32'hFFFF_FFFE, 32'd14}, 33, "div_m100_m7");
        idle();
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, 33, "div_min_m1");
        idle();
        run_div(32'h1234_5678, 32'd0, 1'b0, {32'h1234_5678, 32'hFFFF_FFFF}, ZLAT, "divu_zero");
        idle();
        run_div(32'h1234_5678, 32'd0, 1'b1, {32'h1234_5678, 32'hFFFF_FFFF}, ZLAT, "div_zero");
        idle();
        run_div(32'h8765_4321, 32'd0, 1'b1, {32'h8765_4321, 32'hFFFF_FFFF}, ZLAT, "div_zero_neg");
        idle();

        // Annul at T+10: no ready, result held, new start at T+11 completes at T+44.
        prev = 64'h8765_4321_FFFF_FFFF;
        tick();
        a_i = 32'd1000; b_i = 32'd3; signed_i = 1'b0; start_i = 1'b1;
        for (int k = 1; k < 10; k++) tick();
        tick();
        annul_i = 1'b1;
        #1;
        check("annul_stall", 64'(stall_o), 64'd0);
        check("annul_result_hold", result_o, prev);
        run_div(32'd55, 32'd5, 1'b0, {32'd0, 32'd11}, 33, "after_annul");
        idle();

        // Reset at T+5 mid-divide.
        tick();
        a_i = 32'd100; b_i = 32'd7; signed_i = 1'b0; start_i = 1'b1;
        for (int k = 1; k < 5; k++) tick();
        tick();
        resetn  = 1'b0;
        start_i = 1'b0;
        tick();
        resetn = 1'b1;
        #1;
        check("midrst_stall", 64'(stall_o), 64'd0);
        check("midrst_ready", 64'(ready_o), 64'd0);
        check("midrst_result", result_o, 64'd0);
        tick();
        #1;
        check("midrst_stall2", 64'(stall_o), 64'd0);

        // Back-to-back with start held through DONE.
        run_div(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, "b2b_first");
        run_div(32'd10, 32'd4, 1'b0, {32'd2, 32'd2}, 33, "b2b_second");
        idle();

        // A few random operands checked against the reference model.
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            rs = 1'($urandom_range(0, 1));
            if (rb == 32'd0) rb = 32'd1;
            if (rs && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
            run_div(ra, rb, rs, ref_div(ra, rb, rs), 33, "random");
            idle();
        end

        repeat (3) tick();
        check("pending_results", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
